// File: rtl/uart_rx_flag.sv
// rtl/uart_rx_flag.sv - 8N1 UART receiver with ready/EOT flags and sticky error flags.
// Optional even-parity bit (8E1) and parity_err port enabled by defining UART_RX_PARITY_EN.
module uart_rx_flag #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       clear_rx_flag,
    output logic [7:0] data_out,
    output logic       ready_out,
    output logic       eot_out,
    output logic       frame_err,
    output logic       overrun_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state, state_next;
    logic          rx_meta, rx_sync;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          half_done, bit_done;
    logic          cnt_clr, shift_en, stop_done, accept, frame_set;
    logic          byte_ok;

    assign half_done = (cnt == HALF_LAST);
    assign bit_done  = (cnt == BIT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (!rx_sync) state_next = START;
            START: if (half_done) state_next = rx_sync ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:   if (bit_done && bit_cnt == 3'd7) state_next = PARITY;
            PARITY: if (bit_done) state_next = STOP;
`else
            DATA:  if (bit_done && bit_cnt == 3'd7) state_next = STOP;
`endif
            STOP:  if (bit_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic par_sample, par_bad;
`endif

    always_comb begin
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        stop_done = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_sample = 1'b0;
`endif
        case (state)
            IDLE:  cnt_clr = 1'b1;
            START: cnt_clr = half_done;
            DATA: begin
                cnt_clr  = bit_done;
                shift_en = bit_done;
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                cnt_clr    = bit_done;
                par_sample = bit_done;
            end
`endif
            STOP: begin
                cnt_clr   = bit_done;
                stop_done = bit_done;
            end
            default: cnt_clr = 1'b1;
        endcase
`ifdef UART_RX_PARITY_EN
        byte_ok = !par_bad;
`else
        byte_ok = 1'b1;
`endif
        accept    = stop_done && rx_sync && byte_ok;
        frame_set = stop_done && !rx_sync;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
        end else begin
            cnt <= cnt_clr ? '0 : cnt + CW'(1);
            if (state == IDLE || state == START) bit_cnt <= 3'd0;
            else if (shift_en)                   bit_cnt <= bit_cnt + 3'd1;
            if (shift_en) shift <= {rx_sync, shift[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: data bits plus parity bit must XOR to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (state == IDLE) par_bad <= 1'b0;
            else if (par_sample) par_bad <= (^shift) ^ rx_sync;
            if (par_sample && ((^shift) ^ rx_sync)) parity_err <= 1'b1;
        end
    end
`endif

    // Accept has priority over a coincident clear so a fresh byte is never lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out    <= 8'h00;
            ready_out   <= 1'b0;
            eot_out     <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (accept) begin
                data_out  <= shift;
                ready_out <= 1'b1;
                eot_out   <= (shift == 8'h04);
                if (ready_out) overrun_err <= 1'b1;
            end else if (clear_rx_flag) begin
                ready_out <= 1'b0;
                eot_out   <= 1'b0;
            end
            if (frame_set) frame_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_rx_flag.sv
// tb/tb_uart_rx_flag.sv - directed bench for uart_rx_flag at 16 clocks per bit.
module tb_uart_rx_flag;
    localparam int CLKS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       clear_rx_flag = 1'b0;
    logic [7:0] data_out;
    logic       ready_out, eot_out, frame_err, overrun_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    logic       par_flip = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;
    int lat = 0;

    uart_rx_flag #(.CLKS_PER_BIT(CLKS)) dut (
        .clk(clk), .rst(rst), .rx(rx), .clear_rx_flag(clear_rx_flag),
        .data_out(data_out), .ready_out(ready_out), .eot_out(eot_out),
        .frame_err(frame_err), .overrun_err(overrun_err)
`ifdef UART_RX_PARITY_EN
        , .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic line_bit(input logic b);
        rx = b;
        repeat (CLKS) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        line_bit((^d) ^ par_flip);
`endif
        line_bit(stop_bit);
        line_bit(1'b1);
    endtask

    task automatic pulse_clear();
        clear_rx_flag = 1'b1;
        @(posedge clk);
        #1;
        clear_rx_flag = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", data_out, 8'h00);
        check("rst_ready", ready_out, 0);
        check("rst_eot", eot_out, 0);
        check("rst_frame", frame_err, 0);
        check("rst_overrun", overrun_err, 0);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        fork
            send_frame(8'h68, 1'b1);
            begin
                lat = 0;
                for (int n = 1; n <= 400 && lat == 0; n++) begin
                    @(posedge clk);
                    #1;
                    if (ready_out) lat = n;
                end
            end
        join
        check("h_latency_window", (lat >= 153 && lat <= 157), 1);
        check("h_data", data_out, 8'h68);
        check("h_ready", ready_out, 1);
        check("h_eot", eot_out, 0);
        pulse_clear();
        check("h_cleared", ready_out, 0);

        send_frame(8'h04, 1'b1);
        check("eot_ready", ready_out, 1);
        check("eot_flag", eot_out, 1);
        pulse_clear();
        check("eot_clr_ready", ready_out, 0);
        check("eot_clr_eot", eot_out, 0);
        check("eot_clr_data", data_out, 8'h04);
        check("eot_no_overrun", overrun_err, 0);

        send_frame(8'h65, 1'b1);
        send_frame(8'h6C, 1'b1);
        check("ovr_data", data_out, 8'h6C);
        check("ovr_flag", overrun_err, 1);
        check("ovr_ready", ready_out, 1);
        check("ovr_eot", eot_out, 0);

        pulse_clear();
        send_frame(8'hA5, 1'b0);
        check("ferr_ready", ready_out, 0);
        check("ferr_flag", frame_err, 1);
        check("ferr_data_held", data_out, 8'h6C);
        send_frame(8'h21, 1'b1);
        check("after_ferr_data", data_out, 8'h21);
        check("after_ferr_ready", ready_out, 1);
        check("ferr_sticky", frame_err, 1);
        check("ovr_sticky_on_clear", overrun_err, 1);

        pulse_clear();
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("glitch_ready", ready_out, 0);
        check("glitch_data", data_out, 8'h21);

        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (60) @(posedge clk);
                #2;
                rst = 1'b0;
                #2;
                check("mid_rst_data", data_out, 8'h00);
                check("mid_rst_ready", ready_out, 0);
                check("mid_rst_eot", eot_out, 0);
                check("mid_rst_frame", frame_err, 0);
                check("mid_rst_overrun", overrun_err, 0);
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b1;
            end
        join
        check("post_rst_idle", ready_out, 0);
        send_frame(8'h20, 1'b1);
        check("post_rst_data", data_out, 8'h20);
        check("post_rst_ready", ready_out, 1);
        check("post_rst_eot", eot_out, 0);

`ifdef UART_RX_PARITY_EN
        pulse_clear();
        par_flip = 1'b0;
        send_frame(8'h03, 1'b1);
        check("par_ok_ready", ready_out, 1);
        check("par_ok_data", data_out, 8'h03);
        check("par_ok_err", parity_err, 0);
        pulse_clear();
        par_flip = 1'b1;
        send_frame(8'h03, 1'b1);
        check("par_bad_ready", ready_out, 0);
        check("par_bad_err", parity_err, 1);
        par_flip = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
